mul_pipe_n: RTL and testbench

- Parametrised, pipelined integer multiplier; next generation of the fixed 32-bit, 4-stage multiplier in the ALU/EX path.
- Adds configurable operand width and depth, three operand-sign modes (unsigned, signed, signed×unsigned), a tag that travels with each operation, valid/ready backpressure and a synchronous flush.
- Sits between the decode/issue stage and writeback.
- Returns the full 2W-bit product, so the writeback stage picks the high or low half.

---
 rtl/mul_pipe_n_pkg.sv | 17 +
 rtl/mul_pipe_n_if.sv | 27 ++
 rtl/mul_pipe_n_acc_stage.sv | 74 +++++++
 rtl/mul_pipe_n.sv | 105 ++++++++++
 tb/tb_mul_pipe_n.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pipe_n_pkg.sv
// Shared definitions for the pipelined multiplier: operand-sign modes and
// partial-product slice indexing.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_UU  = 2'b00,
    MUL_SS  = 2'b01,
    MUL_SU  = 2'b10,
    MUL_RSV = 2'b11
  } mul_mode_e;

  // Bit position of the least significant bit of multiplier slice k (0-based).
  function automatic int slice_lsb(input int k, input int w, input int stages);
    return k * (w / stages);
  endfunction

endpackage

// File: rtl/mul_pipe_n_if.sv
// Issue-side and writeback-side handshake bundle of the pipelined multiplier.
interface mul_pipe_n_if #(
    parameter int W     = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_prod;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_mode, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_prod, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, in_tag, flush, out_ready,
        output in_ready, out_valid, out_prod, out_tag
    );
endinterface

// File: rtl/mul_pipe_n_acc_stage.sv
// One registered accumulate stage: adds |A| times one W/STAGES-bit slice of |B|,
// shifted into place, and forwards operands, sign and tag alongside.
module mul_acc_stage
    import mul_pkg::*;
#(
    parameter int W     = 32,
    parameter int STAGES = 4,
    parameter int TAG_W = 5,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv_i,
    input  logic             flush_i,
    input  logic             vld_i,
    input  logic [W-1:0]     a_mag_i,
    input  logic [W-1:0]     b_mag_i,
    input  logic [2*W-1:0]   acc_i,
    input  logic             neg_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             vld_o,
    output logic [W-1:0]     a_mag_o,
    output logic [W-1:0]     b_mag_o,
    output logic [2*W-1:0]   acc_o,
    output logic             neg_o,
    output logic [TAG_W-1:0] tag_o
);
    localparam int S   = W / STAGES;
    localparam int LSB = slice_lsb(IDX, W, STAGES);

    logic [S-1:0]     slice;
    logic [2*W-1:0]   a_ext;
    logic [2*W-1:0]   sl_ext;
    logic [2*W-1:0]   acc_d;
    logic             vld_q;
    logic [W-1:0]     a_mag_q;
    logic [W-1:0]     b_mag_q;
    logic [2*W-1:0]   acc_q;
    logic             neg_q;
    logic [TAG_W-1:0] tag_q;

    assign slice  = b_mag_i[LSB +: S];
    assign a_ext  = {{W{1'b0}}, a_mag_i};
    assign sl_ext = {{(2*W-S){1'b0}}, slice};
    assign acc_d  = acc_i + ((a_ext * sl_ext) << LSB);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= 1'b0;
        end else if (flush_i) begin
            vld_q <= 1'b0;
        end else if (adv_i) begin
            vld_q <= vld_i;
        end
    end

    // Datapath registers carry no reset; only the valid bit qualifies them.
    always_ff @(posedge clk) begin
        if (adv_i) begin
            a_mag_q <= a_mag_i;
            b_mag_q <= b_mag_i;
            acc_q   <= acc_d;
            neg_q   <= neg_i;
            tag_q   <= tag_i;
        end
    end

    assign vld_o   = vld_q;
    assign a_mag_o = a_mag_q;
    assign b_mag_o = b_mag_q;
    assign acc_o   = acc_q;
    assign neg_o   = neg_q;
    assign tag_o   = tag_q;
endmodule

// File: rtl/mul_pipe_n.sv
// Parametrised pipelined integer multiplier with sign modes, tag, global-stall
// backpressure and synchronous flush; returns the full 2W-bit product.
module mul_pipe_n
    import mul_pkg::*;
#(
    parameter int W      = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 5
) (
    input logic         clk,
    input logic         rst,
    mul_pipe_n_if.slave bus
);
    function automatic logic [W-1:0] cond_neg_w(input logic [W-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [2*W-1:0] cond_neg_2w(input logic [2*W-1:0] x, input logic neg);
        logic signed [2*W-1:0] xs;
        xs = $signed(x);
        return neg ? $unsigned(-xs) : x;
    endfunction

    logic             adv;
    logic             fire;
    logic             neg_a;
    logic             neg_b;
    logic             out_valid_q;
    logic [2*W-1:0]   out_prod_q;
    logic [2*W-1:0]   out_prod_d;
    logic [TAG_W-1:0] out_tag_q;
    logic             unused_tail;

    logic             vld_p   [STAGES+1];
    logic [W-1:0]     a_mag_p [STAGES+1];
    logic [W-1:0]     b_mag_p [STAGES+1];
    logic [2*W-1:0]   acc_p   [STAGES+1];
    logic             neg_p   [STAGES+1];
    logic [TAG_W-1:0] tag_p   [STAGES+1];

    // Whole pipe moves together; flush blocks any new accept.
    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv && !bus.flush;
    assign fire         = bus.in_valid && bus.in_ready;

    // Stage 0: sign conditioning, registered by the first accumulate stage.
    assign neg_a = bus.in_a[W-1] && (bus.in_mode == MUL_SS || bus.in_mode == MUL_SU);
    assign neg_b = bus.in_b[W-1] && (bus.in_mode == MUL_SS);

    assign vld_p[0]   = fire;
    assign a_mag_p[0] = cond_neg_w(bus.in_a, neg_a);
    assign b_mag_p[0] = cond_neg_w(bus.in_b, neg_b);
    assign acc_p[0]   = '0;
    assign neg_p[0]   = neg_a ^ neg_b;
    assign tag_p[0]   = bus.in_tag;

    for (genvar k = 1; k <= STAGES; k++) begin : g_stage
        mul_acc_stage #(
            .W      (W),
            .STAGES (STAGES),
            .TAG_W  (TAG_W),
            .IDX    (k - 1)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .adv_i   (adv),
            .flush_i (bus.flush),
            .vld_i   (vld_p[k-1]),
            .a_mag_i (a_mag_p[k-1]),
            .b_mag_i (b_mag_p[k-1]),
            .acc_i   (acc_p[k-1]),
            .neg_i   (neg_p[k-1]),
            .tag_i   (tag_p[k-1]),
            .vld_o   (vld_p[k]),
            .a_mag_o (a_mag_p[k]),
            .b_mag_o (b_mag_p[k]),
            .acc_o   (acc_p[k]),
            .neg_o   (neg_p[k]),
            .tag_o   (tag_p[k])
        );
    end

    assign unused_tail = ^{a_mag_p[STAGES], b_mag_p[STAGES]};

    // Output register: restore the sign of the product.
    assign out_prod_d = cond_neg_2w(acc_p[STAGES], neg_p[STAGES]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_prod_q  <= '0;
            out_tag_q   <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (adv) begin
            out_valid_q <= vld_p[STAGES];
            out_prod_q  <= out_prod_d;
            out_tag_q   <= tag_p[STAGES];
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_prod  = out_prod_q;
    assign bus.out_tag   = out_tag_q;
endmodule

// File: tb/tb_mul_pipe_n.sv
// Scoreboard bench for mul_pipe_n (W=32, STAGES=4): directed vectors, stall,
// flush and asynchronous reset scenarios.
module tb_mul_pipe_n;
    import mul_pkg::*;

    typedef struct packed {
        logic [63:0] prod;
        logic [4:0]  tag;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;
    exp_t q[$];

    mul_pipe_n_if #(.W(32), .TAG_W(5)) bus ();

    mul_pipe_n #(.W(32), .STAGES(4), .TAG_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] m);
        logic signed [63:0] ax;
        logic signed [63:0] bx;
        ax = (m == 2'b01 || m == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        bx = (m == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        return ax * bx;
    endfunction

    // Monitor: pop and compare on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && bus.out_valid && bus.out_ready && !bus.flush) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_result: got prod %h tag %0d, required no output",
                             bus.out_prod, bus.out_tag);
                end else begin
                    e = q.pop_front();
                    chk("sb_prod", bus.out_prod, e.prod);
                    chk("sb_tag", 64'(bus.out_tag), 64'(e.tag));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                        input logic [4:0] tag, input logic [63:0] exp);
        bit ok;
        ok = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_mode  = m;
        bus.in_tag   = tag;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                q.push_back('{prod: exp, tag: tag});
                ok = 1;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (!ok) begin
            n_chk++;
            $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, required accept");
        end
    endtask

    task automatic lat_chk(input string name);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(n), 64'd5);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && q.size() != 0; n++) @(posedge clk);
        #1;
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    logic [31:0] ba [8] = '{32'h1234_5678, 32'h8000_0001, 32'hFFFF_FFFE, 32'h0000_0000,
                            32'h7FFF_FFFF, 32'hDEAD_BEEF, 32'h0000_0013, 32'hC000_0000};
    logic [31:0] bb [8] = '{32'h9ABC_DEF0, 32'h0000_0002, 32'hFFFF_FFFE, 32'h5555_5555,
                            32'h7FFF_FFFF, 32'hCAFE_F00D, 32'hFFFF_FFF3, 32'h8000_0000};
    logic [1:0]  bm [8] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01};

    initial begin
        logic [63:0] held;
        logic [4:0]  held_tag;
        n_chk = 0;
        n_pass = 0;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_mode = '0;
        bus.in_tag = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_prod", bus.out_prod, 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Directed mode vectors, first one timed.
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_UU, 5'd3, 64'hFFFF_FFFE_0000_0001);
        lat_chk("latency_uu");
        drain();
        send(32'h8000_0000, 32'h8000_0000, MUL_SS, 5'd4, 64'h4000_0000_0000_0000);
        send(32'hFFFF_FFFD, 32'h0000_0007, MUL_SS, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_SU, 5'd6, 64'hFFFF_FFFF_0000_0001);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_RSV, 5'd7, 64'hFFFF_FFFE_0000_0001);
        drain();

        // Burst of 8 with a 3-cycle output stall in the middle.
        for (int i = 0; i < 8; i++) begin
            if (i == 6) begin
                bus.out_ready = 1'b0;
                @(negedge clk);
                held = bus.out_prod;
                held_tag = bus.out_tag;
                chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
                for (int j = 0; j < 3; j++) begin
                    if (j > 0) @(negedge clk);
                    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
                    chk("stall_prod_hold", bus.out_prod, held);
                    chk("stall_tag_hold", 64'(bus.out_tag), 64'(held_tag));
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
            send(ba[i], bb[i], bm[i], 5'(16 + i), model(ba[i], bb[i], bm[i]));
        end
        drain();

        // Flush with three operations in flight.
        send(32'h0000_0011, 32'h0000_0022, MUL_UU, 5'd1, 64'h0000_0000_0000_0242);
        send(32'h0000_0033, 32'h0000_0044, MUL_UU, 5'd2, 64'h0000_0000_0000_0D8C);
        send(32'h0000_0055, 32'h0000_0066, MUL_UU, 5'd3, 64'h0000_0000_0000_21DE);
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_a = 32'h0000_0099;
        bus.in_b = 32'h0000_0099;
        bus.in_tag = 5'd30;
        @(negedge clk);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        q.delete();
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        send(32'd12345, 32'd1000, MUL_UU, 5'd9, 64'h0000_0000_00BC_5EA8);
        lat_chk("latency_after_flush");
        drain();

        // Asynchronous reset mid-burst.
        for (int i = 0; i < 6; i++) send(ba[i], bb[i], bm[i], 5'(i), model(ba[i], bb[i], bm[i]));
        #2;
        rst = 1'b0;
        q.delete();
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_out_prod", bus.out_prod, 64'd0);
        chk("arst_out_tag", 64'(bus.out_tag), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (12) @(posedge clk);
        #1;
        send(32'hFFFF_FFFD, 32'h0000_0007, MUL_SU, 5'd12, 64'hFFFF_FFFF_FFFF_FFEB);
        lat_chk("latency_after_reset");
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
